rsa_wshiftreg: RTL and testbench

Word-organised operand register for the RSA Montgomery datapath: a WORD×NWORDS-bit register that can be cleared, parallel-loaded from one of two sources, shifted by one word, or unloaded word-serially under a self-timed sequencer. It sits between the multiplier accumulator and the peripheral data port. It supersedes the single-width clear/load register by adding word shifting and a streaming read-out with busy/done handshake.

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/rsa_wshiftreg_seq.sv | 72 +++++++
 rtl/rsa_wshiftreg.sv | 79 +++++++
 tb/tb_rsa_wshiftreg.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types for the RSA Montgomery datapath registers: command encoding,
// stream sequencer states and a helper for sizing word counters.
package rsa_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'd0,
    OP_LOAD   = 2'd1,
    OP_SHIFT  = 2'd2,
    OP_ROTATE = 2'd3
  } op_e;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } stream_state_e;

  function automatic int count_width(input int nwords);
    return (nwords > 1) ? $clog2(nwords) : 1;
  endfunction

endpackage

// File: rtl/rsa_wshiftreg_seq.sv
// Self-timed read-out sequencer: counts streamed words, latches the fill mode
// at start and produces the one-cycle done pulse after the last word.
module rsa_wshiftreg_seq
  import rsa_pkg::*;
#(
  parameter int NWORDS = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic ena,
  input  logic clear,
  input  logic start,
  input  logic circ,
  output logic busy,
  output logic done,
  output logic fill_circ
);

  localparam int CW = count_width(NWORDS);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  stream_state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          circ_q, circ_d;

  // done only lives for one enabled cycle; ena=0 freezes it so it stretches.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    circ_d  = circ_q;
    if (ena) begin
      done_d = 1'b0;
      if (!clear) begin
        state_d = S_IDLE;
        count_d = '0;
      end else if (state_q == S_STREAM) begin
        if (count_q == LAST) begin
          state_d = S_IDLE;
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + 1'b1;
        end
      end else if (start) begin
        state_d = S_STREAM;
        count_d = '0;
        circ_d  = circ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= S_IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
      circ_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      circ_q  <= circ_d;
    end
  end

  assign busy      = (state_q == S_STREAM);
  assign done      = done_q;
  assign fill_circ = circ_q;

endmodule

// File: rtl/rsa_wshiftreg.sv
// Word-organised operand register: clear, dual-source load, word shift/rotate
// and a word-serial read-out driven by rsa_wshiftreg_seq.
module rsa_wshiftreg
  import rsa_pkg::*;
#(
  parameter int WORD   = 8,
  parameter int NWORDS = 4,
  localparam int WIDTH = WORD * NWORDS
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             clear,
  input  logic [1:0]       op,
  input  logic             lock,
  input  logic [WIDTH-1:0] reg_rji,
  input  logic [WIDTH-1:0] A,
  input  logic [WORD-1:0]  ser_in,
  input  logic             start,
  input  logic             circ,
  output logic [WIDTH-1:0] R_i,
  output logic [WORD-1:0]  out_word,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] r_q, r_d;
  logic             fill_circ;
  logic [WORD-1:0]  fill_word;
  op_e              op_cmd;

  rsa_wshiftreg_seq #(
    .NWORDS(NWORDS)
  ) u_seq (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .clear    (clear),
    .start    (start),
    .circ     (circ),
    .busy     (busy),
    .done     (done),
    .fill_circ(fill_circ)
  );

  assign op_cmd    = op_e'(op);
  assign fill_word = fill_circ ? r_q[WORD-1:0] : '0;

  // Streaming owns the register while busy; start wins over op when idle.
  always_comb begin
    r_d = r_q;
    if (ena) begin
      if (!clear) begin
        r_d = '0;
      end else if (busy) begin
        r_d = {fill_word, r_q[WIDTH-1:WORD]};
      end else if (!start) begin
        unique case (op_cmd)
          OP_HOLD:   r_d = r_q;
          OP_LOAD:   r_d = lock ? reg_rji : A;
          OP_SHIFT:  r_d = {ser_in, r_q[WIDTH-1:WORD]};
          OP_ROTATE: r_d = {r_q[WORD-1:0], r_q[WIDTH-1:WORD]};
          default:   r_d = r_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) r_q <= '0;
    else       r_q <= r_d;
  end

  assign R_i       = r_q;
  assign out_word  = r_q[WORD-1:0];
  assign out_valid = busy & ena;

endmodule

// File: tb/tb_rsa_wshiftreg.sv
// Self-checking bench for rsa_wshiftreg: directed vector table, hand-written
// stream sequences and randomized traffic against a word-queue reference model.
module tb_rsa_wshiftreg;
  import rsa_pkg::*;

  localparam int W = 8;
  localparam int N = 4;
  localparam int WIDTH = W * N;

  logic             clk;
  logic             rstb;
  logic             ena;
  logic             clear;
  logic [1:0]       op;
  logic             lock;
  logic [WIDTH-1:0] regRji;
  logic [WIDTH-1:0] aIn;
  logic [W-1:0]     serIn;
  logic             start;
  logic             circ;
  logic [WIDTH-1:0] rOut;
  logic [W-1:0]     outWord;
  logic             outValid;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;

  // Reference model: register value, stream status and the queue of words
  // still owed by the current stream (snapshotted when the stream starts).
  logic [WIDTH-1:0] mR;
  bit               mBusy;
  bit               mDone;
  bit               mCirc;
  logic [W-1:0]     expQ[$];

  typedef struct {
    logic [1:0]       op;
    logic             lock;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] rji;
    logic [W-1:0]     ser;
    logic [WIDTH-1:0] expR;
  } vec_t;

  vec_t         vecs[5];
  logic [W-1:0] words[N];

  rsa_wshiftreg #(
    .WORD  (W),
    .NWORDS(N)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .ena      (ena),
    .clear    (clear),
    .op       (op),
    .lock     (lock),
    .reg_rji  (regRji),
    .A        (aIn),
    .ser_in   (serIn),
    .start    (start),
    .circ     (circ),
    .R_i      (rOut),
    .out_word (outWord),
    .out_valid(outValid),
    .busy     (busy),
    .done     (done)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison: counts it and reports any disagreement.
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advances the model across one clock edge using the currently driven inputs.
  task automatic modelStep();
    logic [W-1:0] lsw;
    if (!rstb) begin
      mR = '0; mBusy = 0; mDone = 0; mCirc = 0;
      expQ.delete();
    end else if (ena) begin
      mDone = 0;
      if (!clear) begin
        mR = '0; mBusy = 0;
        expQ.delete();
      end else if (mBusy) begin
        lsw = mR[W-1:0];
        mR = mR >> W;
        if (mCirc) mR[WIDTH-1 -: W] = lsw;
        void'(expQ.pop_front());
        if (expQ.size() == 0) begin
          mBusy = 0;
          mDone = 1;
        end
      end else if (start) begin
        mCirc = circ;
        mBusy = 1;
        for (int k = 0; k < N; k++) expQ.push_back(mR[k*W +: W]);
      end else begin
        case (op)
          2'd1: mR = lock ? regRji : aIn;
          2'd2: begin mR = mR >> W; mR[WIDTH-1 -: W] = serIn; end
          2'd3: begin lsw = mR[W-1:0]; mR = mR >> W; mR[WIDTH-1 -: W] = lsw; end
          default: ;
        endcase
      end
    end
  endtask

  // Compares every DUT output with the model for the current cycle.
  task automatic checkModel();
    logic [W-1:0] expWord;
    bit           expValid;
    expValid = mBusy && ena;
    expWord  = expValid ? expQ[0] : mR[W-1:0];
    checkOutput("R_i", rOut, mR);
    checkOutput("busy", {31'b0, busy}, {31'b0, mBusy});
    checkOutput("done", {31'b0, done}, {31'b0, mDone});
    checkOutput("out_valid", {31'b0, outValid}, {31'b0, expValid});
    checkOutput("out_word", {24'b0, outWord}, {24'b0, expWord});
  endtask

  // One clock with the inputs as currently driven, then full comparison.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkModel();
  endtask

  task automatic idleInputs();
    rstb = 1; ena = 1; clear = 1; op = 2'd0; start = 0;
  endtask

  task automatic loadValue(input logic [WIDTH-1:0] v);
    idleInputs();
    op = 2'd1; lock = 0; aIn = v;
    applyStimulus();
    op = 2'd0;
  endtask

  initial begin
    rstb = 0; ena = 1; clear = 1; op = 2'd0; lock = 0;
    regRji = '0; aIn = '0; serIn = '0; start = 0; circ = 0;
    mR = '0; mBusy = 0; mDone = 0; mCirc = 0;

    applyStimulus();
    applyStimulus();

    // Reset after a load must wipe the register.
    loadValue(32'hDEADBEEF);
    checkOutput("load_before_reset", rOut, 32'hDEADBEEF);
    rstb = 0;
    applyStimulus();
    checkOutput("reset_R", rOut, 32'h0);
    checkOutput("reset_busy", {31'b0, busy}, 32'h0);
    checkOutput("reset_done", {31'b0, done}, 32'h0);
    rstb = 1;

    vecs[0] = '{2'd1, 1'b1, 32'hCAFEF00D, 32'h12345678, 8'h00, 32'h12345678};
    vecs[1] = '{2'd1, 1'b0, 32'hCAFEF00D, 32'h12345678, 8'h00, 32'hCAFEF00D};
    vecs[2] = '{2'd1, 1'b0, 32'h11223344, 32'h0,        8'h00, 32'h11223344};
    vecs[3] = '{2'd2, 1'b0, 32'h0,        32'h0,        8'hAA, 32'hAA112233};
    vecs[4] = '{2'd3, 1'b0, 32'h0,        32'h0,        8'h55, 32'h33AA1122};
    for (int i = 0; i < 5; i++) begin
      idleInputs();
      op = vecs[i].op; lock = vecs[i].lock; aIn = vecs[i].a;
      regRji = vecs[i].rji; serIn = vecs[i].ser;
      applyStimulus();
      checkOutput($sformatf("vec%0d", i), rOut, vecs[i].expR);
    end

    // Rotating stream: words appear LSW first and the register is restored.
    words = '{8'h11, 8'h22, 8'h33, 8'h44};
    loadValue(32'h44332211);
    start = 1; circ = 1;
    applyStimulus();
    start = 0;
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("circ_word%0d", k), {24'b0, outWord}, {24'b0, words[k]});
      checkOutput($sformatf("circ_valid%0d", k), {31'b0, outValid}, 32'h1);
      applyStimulus();
    end
    checkOutput("circ_done", {31'b0, done}, 32'h1);
    checkOutput("circ_R", rOut, 32'h44332211);
    applyStimulus();
    checkOutput("circ_done_drop", {31'b0, done}, 32'h0);

    // Zero-fill stream leaves the register empty.
    start = 1; circ = 0;
    applyStimulus();
    start = 0;
    for (int k = 0; k < N; k++) applyStimulus();
    checkOutput("zero_done", {31'b0, done}, 32'h1);
    checkOutput("zero_R", rOut, 32'h0);

    // Stall with ena low after word 1; ordering resumes intact.
    loadValue(32'h44332211);
    start = 1; circ = 1;
    applyStimulus();
    start = 0;
    applyStimulus();
    applyStimulus();
    ena = 0;
    applyStimulus();
    checkOutput("stall_valid", {31'b0, outValid}, 32'h0);
    applyStimulus();
    ena = 1;
    #1;
    checkOutput("stall_word2", {24'b0, outWord}, 32'h33);
    applyStimulus();
    checkOutput("stall_word3", {24'b0, outWord}, 32'h44);
    applyStimulus();
    checkOutput("stall_done", {31'b0, done}, 32'h1);
    // done must stretch while ena is low.
    ena = 0;
    applyStimulus();
    checkOutput("done_stretch", {31'b0, done}, 32'h1);
    ena = 1;
    applyStimulus();

    // Abort with clear after word 1: no done pulse.
    loadValue(32'h44332211);
    start = 1; circ = 1;
    applyStimulus();
    start = 0;
    applyStimulus();
    clear = 0;
    applyStimulus();
    checkOutput("abort_R", rOut, 32'h0);
    checkOutput("abort_busy", {31'b0, busy}, 32'h0);
    clear = 1;
    applyStimulus();
    checkOutput("abort_no_done", {31'b0, done}, 32'h0);

    // Start beats LOAD; SHIFT/start during the stream are ignored.
    words = '{8'h88, 8'h77, 8'h66, 8'h55};
    loadValue(32'h55667788);
    op = 2'd1; aIn = 32'h99999999; start = 1; circ = 1;
    applyStimulus();
    checkOutput("coll_R", rOut, 32'h55667788);
    checkOutput("coll_busy", {31'b0, busy}, 32'h1);
    op = 2'd2; serIn = 8'hFF;
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("coll_word%0d", k), {24'b0, outWord}, {24'b0, words[k]});
      applyStimulus();
    end
    checkOutput("coll_done", {31'b0, done}, 32'h1);
    checkOutput("coll_final_R", rOut, 32'h55667788);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rstb   = ($urandom_range(0, 99) >= 2);
      clear  = ($urandom_range(0, 99) >= 4);
      ena    = ($urandom_range(0, 99) >= 15);
      start  = ($urandom_range(0, 99) < 15);
      circ   = $urandom_range(0, 1);
      op     = 2'($urandom_range(0, 3));
      lock   = $urandom_range(0, 1);
      aIn    = $urandom;
      regRji = $urandom;
      serIn  = 8'($urandom);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
